dmem_ws: RTL and testbench

- Parametrised data memory for the single-cycle/multicycle processor family; successor to the fixed 1024-word data memory.
- Adds byte/halfword/word access with load sign/zero extension and per-lane write enables.
- Adds a configurable wait-state count with a req/ready handshake, so cores can be tested against slow memory.
- Adds error reporting for misaligned, out-of-range and reserved-size accesses.
- Sits between the core's data port (daddr/ddata_w/ddata_r/d_rw) and the testbench or top level.

---
 rtl/dmem_ws.sv | 175 +++++++++++++++++
 tb/tb_dmem_ws.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws.sv
// dmem_ws: parametrised data memory with byte/halfword/word access,
// load sign/zero extension, a configurable wait-state count behind a
// req/ready handshake, and error reporting for rejected accesses.
module dmem_ws #(
  parameter int    DEPTH     = 1024,
  parameter int    WAIT      = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;

  // Request latched at acceptance; held stable until the response.
  logic        we_p0;
  logic        uns_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic [29:0] widx;
  logic [1:0]  lane;
  logic        err_c;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rd_word;
  logic        wr_en;

  logic        ready_nxt;
  logic        busy_nxt;
  logic        err_nxt;
  logic [31:0] rdata_nxt;

  // Extract the addressed byte/halfword from a word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic        zext,
                                              input logic [1:0]  ln);
    logic [31:0] sh;
    logic [31:0] res;
    res = word;
    case (sz)
      2'b00: begin
        sh  = word >> {ln, 3'b000};
        res = zext ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = word >> {ln[1], 4'b0000};
        res = zext ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // New requests are only taken when idle and not finishing a response.
  assign accept  = (state == S_IDLE) && req && !busy;
  assign widx    = addr_p0[31:2];
  assign lane    = addr_p0[1:0];
  assign rd_word = mem[widx[AW-1:0]];

  // Rejection rules: reserved size, misalignment, index past the array.
  assign err_c = (size_p0 == 2'b11)
              || ((size_p0 == 2'b01) && addr_p0[0])
              || ((size_p0 == 2'b10) && (addr_p0[1:0] != 2'b00))
              || ({2'b00, widx} >= 32'(DEPTH));

  // Store only from RESP, never for a rejected access, never under reset.
  assign wr_en = (state == S_RESP) && we_p0 && !err_c && !RESET;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> (WAIT x WAIT) -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (WAIT > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait-state counter, loaded on acceptance and counted down in WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                cnt <= 4'd0;
    else if (accept)          cnt <= 4'(WAIT);
    else if (state == S_WAIT) cnt <= cnt - 4'd1;
  end

  // Latch the request fields on acceptance.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_p0    <= we;
      uns_p0   <= uns;
      size_p0  <= size;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  // Lane enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wword = wdata_p0;
    case (size_p0)
      2'b00: begin be = 4'b0001 << lane; wword = {4{wdata_p0[7:0]}};  end
      2'b01: begin be = 4'b0011 << lane; wword = {2{wdata_p0[15:0]}}; end
      2'b10: begin be = 4'b1111;         wword = wdata_p0;            end
      default: be = 4'b0000;
    endcase
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wword[8*i +: 8];
    end
  end

  // Output logic: response values produced in RESP, busy cleared after ready.
  always_comb begin
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    busy_nxt  = busy;
    rdata_nxt = rdata;
    if (accept) busy_nxt = 1'b1;
    if (ready)  busy_nxt = 1'b0;
    if (state == S_RESP) begin
      ready_nxt = 1'b1;
      err_nxt   = err_c;
      rdata_nxt = (err_c || we_p0) ? 32'h0
                                   : load_extend(rd_word, size_p0, uns_p0, lane);
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ready <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ready <= ready_nxt;
      busy  <= busy_nxt;
      err   <= err_nxt;
      rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: two instances (WAIT=0 and WAIT=3) share one request
// stream; each access is checked on both against a byte-array model.
module tb_dmem_ws;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, busy0, busy3, err0, err3;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mb [DEPTH*4];
  logic [31:0] rd;

  always #5 clk = ~clk;

  dmem_ws #(.DEPTH(DEPTH), .WAIT(0), .INIT_FILE("")) u_dut0 (
    .CLK(clk), .RESET(rst0), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
    .busy(busy0), .err(err0));

  dmem_ws #(.DEPTH(DEPTH), .WAIT(3), .INIT_FILE("")) u_dut3 (
    .CLK(clk), .RESET(rst3), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3),
    .busy(busy3), .err(err3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit u, input logic [31:0] a);
    int v;
    if (sz == 2'b00) begin
      v = mb[a];
      if (!u && v >= 128) v -= 256;
      return 32'(v);
    end else if (sz == 2'b01) begin
      v = mb[a] + 256 * mb[a+1];
      if (!u && v >= 32768) v -= 65536;
      return 32'(v);
    end
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int nb;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < nb; i++) mb[a+i] = d[8*i +: 8];
  endtask

  // One access on both instances; poke re-requests mid-flight, abort resets mid-flight.
  task automatic access(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit poke, input bit abort, output logic [31:0] r);
    int n0, n3, k0, k3;
    logic [31:0] r0, r3;
    logic e0, e3, b0a, b3a, b0r, b3r;
    bit exp_err;
    logic [31:0] exp_rd;
    exp_err = m_err(sz, a);
    exp_rd  = 32'h0;
    if (!exp_err && !w) exp_rd = m_load(sz, u, a);
    n0 = 0; n3 = 0; k0 = -1; k3 = -1;
    r0 = 'x; r3 = 'x; e0 = 'x; e3 = 'x;
    b0a = 1'b1; b3a = 1'b1; b0r = 1'b0; b3r = 1'b0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    chk("busy0_acc", {31'h0, busy0}, 32'h1);
    chk("busy3_acc", {31'h0, busy3}, 32'h1);
    if (abort) rst0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ready0) begin n0++; k0 = k; r0 = rdata0; e0 = err0; b0r = busy0; end
      if (ready3) begin n3++; k3 = k; r3 = rdata3; e3 = err3; b3r = busy3; end
      if (k0 > 0 && k == k0 + 1) b0a = busy0;
      if (k3 > 0 && k == k3 + 1) b3a = busy3;
      if (poke && k == 1) begin
        req = 1'b1; we = 1'b1; size = 2'b10; addr = a ^ 32'h20; wdata = ~d;
      end
      if (poke && k == 2) req = 1'b0;
      if (abort && k == 1) rst3 = 1'b1;
      if (abort && k == 2) begin rst0 = 1'b0; rst3 = 1'b0; end
    end
    if (abort) begin
      chk("abort_ready0", 32'(n0), 32'd0);
      chk("abort_ready3", 32'(n3), 32'd0);
      chk("abort_busy0", {31'h0, busy0}, 32'h0);
      chk("abort_busy3", {31'h0, busy3}, 32'h0);
      chk("abort_rdata3", rdata3, 32'h0);
      r = 32'h0;
      return;
    end
    chk("npulse0", 32'(n0), 32'd1);
    chk("npulse3", 32'(n3), 32'd1);
    chk("lat0", 32'(k0), 32'd1);
    chk("lat3", 32'(k3), 32'd4);
    chk("err0", {31'h0, e0}, {31'h0, exp_err});
    chk("err3", {31'h0, e3}, {31'h0, exp_err});
    chk("busy0_rdy", {31'h0, b0r}, 32'h1);
    chk("busy3_rdy", {31'h0, b3r}, 32'h1);
    chk("busy0_after", {31'h0, b0a}, 32'h0);
    chk("busy3_after", {31'h0, b3a}, 32'h0);
    if (!w || exp_err) begin
      chk("rdata0", r0, exp_rd);
      chk("rdata3", r3, exp_rd);
    end
    if (w && !exp_err) m_store(sz, a, d);
    r = r3;
  endtask

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata3", rdata3, 32'h0);
    chk("rst_ready0", {31'h0, ready0}, 32'h0);
    chk("rst_ready3", {31'h0, ready3}, 32'h0);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_busy3", {31'h0, busy3}, 32'h0);
    chk("rst_err0", {31'h0, err0}, 32'h0);
    chk("rst_err3", {31'h0, err3}, 32'h0);
    rst0 = 1'b0; rst3 = 1'b0;

    // Fill every word so no load ever sees uninitialised contents.
    for (int i = 0; i < DEPTH; i++) access(1, 2'b10, 0, 32'(i * 4), $urandom, 0, 0, rd);

    // Reset during the second wait cycle of a store.
    access(1, 2'b10, 0, 32'h10, 32'h0, 0, 0, rd);
    access(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 1, rd);
    access(0, 2'b10, 0, 32'h10, 32'h0, 0, 0, rd);
    chk("abort_nowrite", rd, 32'h0);

    // Word store/load round trip.
    access(1, 2'b10, 0, 32'h40, 32'h12345678, 0, 0, rd);
    access(0, 2'b10, 0, 32'h40, 32'h0, 0, 0, rd);
    chk("lw_40", rd, 32'h12345678);

    // Byte and halfword stores into a word.
    access(1, 2'b10, 0, 32'h0, 32'h11223344, 0, 0, rd);
    access(1, 2'b00, 0, 32'h2, 32'h000000AA, 0, 0, rd);
    access(0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd);
    chk("sb_2", rd, 32'h11AA3344);
    access(1, 2'b01, 0, 32'h0, 32'h0000BEEF, 0, 0, rd);
    access(0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd);
    chk("sh_0", rd, 32'h11AABEEF);

    // Load extension.
    access(1, 2'b10, 0, 32'h8, 32'h80FF7F01, 0, 0, rd);
    access(0, 2'b00, 0, 32'hB, 32'h0, 0, 0, rd); chk("lb_B", rd, 32'hFFFFFF80);
    access(0, 2'b00, 1, 32'hB, 32'h0, 0, 0, rd); chk("lbu_B", rd, 32'h00000080);
    access(0, 2'b00, 0, 32'h8, 32'h0, 0, 0, rd); chk("lb_8", rd, 32'h00000001);
    access(0, 2'b01, 0, 32'hA, 32'h0, 0, 0, rd); chk("lh_A", rd, 32'hFFFF80FF);
    access(0, 2'b01, 1, 32'hA, 32'h0, 0, 0, rd); chk("lhu_A", rd, 32'h000080FF);

    // Rejected stores must not touch memory.
    access(1, 2'b10, 0, 32'h6, 32'hCAFEF00D, 0, 0, rd);
    access(1, 2'b01, 0, 32'h3, 32'hCAFEF00D, 0, 0, rd);
    access(1, 2'b11, 0, 32'h0, 32'hCAFEF00D, 0, 0, rd);
    access(1, 2'b10, 0, 32'(DEPTH * 4), 32'hCAFEF00D, 0, 0, rd);
    access(0, 2'b10, 0, 32'h0, 32'h0, 0, 0, rd); chk("err_keep0", rd, 32'h11AABEEF);
    access(0, 2'b10, 0, 32'h4, 32'h0, 0, 0, rd);
    access(0, 2'b10, 0, 32'h6, 32'h0, 0, 0, rd);
    access(0, 2'b11, 0, 32'h8, 32'h0, 0, 0, rd);

    // A second request while busy is dropped.
    access(1, 2'b10, 0, 32'h40, 32'h0BADF00D, 1, 0, rd);
    access(0, 2'b10, 0, 32'h60, 32'h0, 0, 0, rd);
    access(0, 2'b10, 0, 32'h40, 32'h0, 0, 0, rd); chk("poke_first", rd, 32'h0BADF00D);

    // Randomised mix including misaligned, reserved and out-of-range accesses.
    for (int i = 0; i < 250; i++) begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      rsz = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64))
                                         : 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'b01) ra[0] = 1'b0;
        if (rsz == 2'b10) ra[1:0] = 2'b00;
      end
      access(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom, 0, 0, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
